// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces h/v counters, sync, data-enable, active-area coordinates, a
// lookahead pixel-fetch request and line/frame start strobes. Every output
// is a register decoded from the next-state counters, so all of them line
// up with the h_cnt/v_cnt they describe.
// Optional: define VGA_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12,
  parameter int REQ_LEAD = 2
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA0_I   = H_SYNC + H_BACK;
  localparam int VA0_I   = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_W   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_W   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA0    = CNT_W'(HA0_I);
  localparam logic [CNT_W-1:0] HA1    = CNT_W'(HA0_I + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA0    = CNT_W'(VA0_I);
  localparam logic [CNT_W-1:0] VA1    = CNT_W'(VA0_I + V_ACTIVE);
  // Request window is the active window shifted early by REQ_LEAD pixels.
  localparam logic [CNT_W-1:0] RQ0    = CNT_W'(HA0_I - REQ_LEAD);
  localparam logic [CNT_W-1:0] RQ1    = CNT_W'(HA0_I + H_ACTIVE - REQ_LEAD);

  // The lead must stay inside the back porch so the request never spans lines.
  if (REQ_LEAD < 1 || REQ_LEAD > H_BACK) begin : g_bad_lead
    $error("vga_timing_gen: REQ_LEAD must be within 1..H_BACK");
  end
  if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_w
    $error("vga_timing_gen: CNT_W too small for the timing totals");
  end

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             req_q, req_d, ls_q, ls_d, fs_q, fs_d;
  logic             v_act;

  // Next-state counters, strobes and output decode of those next-state values.
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    v_act = (v_d >= VA0) && (v_d < VA1);
    hs_d  = (h_d < HS_W) ? HS_POL : ~HS_POL;
    vs_d  = (v_d < VS_W) ? VS_POL : ~VS_POL;
    de_d  = (h_d >= HA0) && (h_d < HA1) && v_act;
    req_d = (h_d >= RQ0) && (h_d < RQ1) && v_act;
    x_d   = de_d ? (h_d - HA0) : '0;
    y_d   = de_d ? (v_d - VA0) : '0;
  end

  // State and output registers; reset parks the raster at (0,0) without strobes.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= HS_POL;
      vs_q  <= VS_POL;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      req_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      x_q   <= x_d;
      y_q   <= y_d;
      req_q <= req_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_req     = req_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  // Frame counter steps on the same cycle frame_start is registered.
  always_comb begin
    fc_d = fc_q;
    if (fs_d) fc_d = fc_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) fc_q <= '0;
    else        fc_q <= fc_d;
  end

  assign frame_cnt = fc_q;
`endif

endmodule
